// File: rtl/grf_pkg.sv
// Shared constants and helpers for the multiport general register file.
// Imported by the storage top and the pending-register scoreboard.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Low bit of element idx in a flattened bus of w-bit elements.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, popcount register,
// and per-read-port busy lookup with optional same-cycle writeback bypass.
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] set_v;
    logic [DEPTH-1:0] clr_v;
    logic [DEPTH-1:0] pend_nxt;
    logic [ADDR_W:0]  cnt_nxt;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
    endfunction

    // A new reservation beats a writeback to the same register.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (rsv_en && !is_zero(rsv_addr)) begin
            set_v[rsv_addr] = 1'b1;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                clr_v[wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] = 1'b1;
            end
        end
        pend_nxt = set_v | (pend & ~clr_v);
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt = cnt_nxt + (ADDR_W + 1)'(pend_nxt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

        always_comb begin
            rd_busy[i] = pend[a];
            if ((BYPASS != 0) && clr_v[a]) begin
                rd_busy[i] = 1'b0;
            end
            if (is_zero(a)) begin
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/grf_multiport.sv
// Parametrised multiport general register file with write-through bypass
// and a pending-producer scoreboard for the hazard unit.
module grf_multiport
    import grf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] wa   [NUM_WR];
    logic [DATA_W-1:0] wd   [NUM_WR];

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
    endfunction

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
        assign wa[j] = wr_addr[slice_lo(j, ADDR_W) +: ADDR_W];
        assign wd[j] = wr_data[slice_lo(j, DATA_W) +: DATA_W];
    end

    // Later ports are issued last, so the highest index wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !is_zero(wa[j])) begin
                    regs[wa[j]] <= wd[j];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        assign a = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

        always_comb begin
            d = regs[a];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wa[j] == a)) begin
                        d = wd[j];
                    end
                end
            end
            if (is_zero(a)) begin
                d = '0;
            end
        end

        assign rd_data[slice_lo(i, DATA_W) +: DATA_W] = d;
    end

    grf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .pend_cnt(pend_cnt)
    );

endmodule

// File: tb/tb_grf_multiport.sv
// Bench for grf_multiport: a 2-write-port bypassing build (a) and a
// 1-write-port non-bypassing build (b) sharing stimulus, against an array model.
module tb_grf_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] a_rd_data, b_rd_data;
    logic [NR-1:0] a_busy, b_busy;
    logic [NW-1:0] wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic rsv_en;
    logic [AW-1:0] rsv_addr;
    logic [AW:0] a_cnt, b_cnt;

    logic [DW-1:0] ma [DEPTH];
    logic [DW-1:0] mb [DEPTH];
    bit pa [DEPTH];
    bit pb [DEPTH];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    grf_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW),
        .ZERO_REG(1), .BYPASS(1)
    ) u_a (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(a_cnt)
    );

    grf_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(1),
        .ZERO_REG(1), .BYPASS(0)
    ) u_b (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_busy),
        .wr_en(wr_en[0:0]), .wr_addr(wr_addr[AW-1:0]),
        .wr_data(wr_data[DW-1:0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(b_cnt)
    );

    function automatic int count_a();
        int c = 0;
        for (int r = 0; r < DEPTH; r++) c += int'(pa[r]);
        return c;
    endfunction

    function automatic int count_b();
        int c = 0;
        for (int r = 0; r < DEPTH; r++) c += int'(pb[r]);
        return c;
    endfunction

    // Advance one clock; the model applies the rules to the sampled inputs.
    task automatic tick();
        bit ca [DEPTH];
        bit cb [DEPTH];
        int w;
        @(posedge clk);
        for (int r = 0; r < DEPTH; r++) begin
            ca[r] = 1'b0;
            cb[r] = 1'b0;
        end
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                ma[r] = '0; mb[r] = '0; pa[r] = 1'b0; pb[r] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wr_en[j]) begin
                    w = int'(wr_addr[j*AW +: AW]);
                    ca[w] = 1'b1;
                    if (j == 0) cb[w] = 1'b1;
                    if (w != 0) begin
                        ma[w] = wr_data[j*DW +: DW];
                        if (j == 0) mb[w] = wr_data[j*DW +: DW];
                    end
                end
            end
            for (int r = 1; r < DEPTH; r++) begin
                if (rsv_en && int'(rsv_addr) == r) begin
                    pa[r] = 1'b1;
                    pb[r] = 1'b1;
                end else begin
                    if (ca[r]) pa[r] = 1'b0;
                    if (cb[r]) pb[r] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        wr_en = '0;
        rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234};
        tick();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        reset = 1'b1;
        wr_en = 2'b01; wr_data = {32'h0, 32'h9999};
        tick();
        reset = 1'b0;
        idle();
        rd_addr = {5'd5, 5'd5};
        #2;
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h0) begin
            n_err++; $display("FAIL reset_rd_a got %h want 0", a_rd_data[31:0]);
        end
        n_cmp++;
        if (b_rd_data[31:0] !== 32'h0) begin
            n_err++; $display("FAIL reset_rd_b got %h want 0", b_rd_data[31:0]);
        end
        n_cmp++;
        if (a_busy !== 2'b00) begin
            n_err++; $display("FAIL reset_busy got %b want 00", a_busy);
        end
        n_cmp++;
        if (a_cnt !== 6'd0 || b_cnt !== 6'd0) begin
            n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", a_cnt, b_cnt);
        end
    endtask

    task automatic test_bypass();
        rd_addr = {5'd0, 5'd8};
        wr_en = 2'b01; wr_addr = {5'd0, 5'd8}; wr_data = {32'h0, 32'hDEADBEEF};
        #2;
        n_cmp++;
        if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_a got %h want deadbeef", a_rd_data[31:0]);
        end
        n_cmp++;
        if (b_rd_data[31:0] !== 32'h0) begin
            n_err++; $display("FAIL nobypass_old got %h want 0", b_rd_data[31:0]);
        end
        tick();
        idle();
        #2;
        n_cmp++;
        if (b_rd_data[31:0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL nobypass_new got %h want deadbeef", b_rd_data[31:0]);
        end
        n_cmp++;
        if (a_rd_data[31:0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_held got %h want deadbeef", a_rd_data[31:0]);
        end
    endtask

    task automatic test_zero();
        rd_addr = {5'd0, 5'd0};
        wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'hFFFFFFFF};
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #2;
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h0 || b_rd_data[31:0] !== 32'h0) begin
            n_err++; $display("FAIL zero_rd got %h/%h want 0", a_rd_data[31:0], b_rd_data[31:0]);
        end
        tick();
        idle();
        #2;
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h0 || a_busy[0] !== 1'b0) begin
            n_err++; $display("FAIL zero_after got %h busy %b want 0/0", a_rd_data[31:0], a_busy[0]);
        end
        n_cmp++;
        if (a_cnt !== 6'd0) begin
            n_err++; $display("FAIL zero_cnt got %0d want 0", a_cnt);
        end
    endtask

    task automatic test_priority();
        rd_addr = {5'd0, 5'd3};
        wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h22, 32'h11};
        #2;
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h22) begin
            n_err++; $display("FAIL prio_bypass got %h want 22", a_rd_data[31:0]);
        end
        tick();
        idle();
        #2;
        n_cmp++;
        if (a_rd_data[31:0] !== 32'h22) begin
            n_err++; $display("FAIL prio_stored got %h want 22", a_rd_data[31:0]);
        end
        n_cmp++;
        if (b_rd_data[31:0] !== 32'h11) begin
            n_err++; $display("FAIL prio_single got %h want 11", b_rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd9, 5'd0};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        #2;
        n_cmp++;
        if (a_busy[1] !== 1'b0) begin
            n_err++; $display("FAIL sb_rsv_same got %b want 0", a_busy[1]);
        end
        tick();
        idle();
        #2;
        n_cmp++;
        if (a_busy[1] !== 1'b1 || b_busy[1] !== 1'b1 || a_cnt !== 6'd1) begin
            n_err++; $display("FAIL sb_pending got %b/%b cnt %0d want 1/1 cnt 1", a_busy[1], b_busy[1], a_cnt);
        end
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        #2;
        n_cmp++;
        if (a_busy[1] !== 1'b0 || b_busy[1] !== 1'b1) begin
            n_err++; $display("FAIL sb_wb_busy got %b/%b want 0/1", a_busy[1], b_busy[1]);
        end
        tick();
        idle();
        n_cmp++;
        if (a_cnt !== 6'd0 || b_cnt !== 6'd0) begin
            n_err++; $display("FAIL sb_wb_cnt got %0d/%0d want 0/0", a_cnt, b_cnt);
        end
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h77, 32'h0};
        tick();
        idle();
        #2;
        n_cmp++;
        if (a_busy[1] !== 1'b1 || a_cnt !== 6'd1) begin
            n_err++; $display("FAIL sb_rsv_wins got %b cnt %0d want 1 cnt 1", a_busy[1], a_cnt);
        end
    endtask

    task automatic test_fill();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            rsv_en = 1'b1; rsv_addr = AW'(r);
            tick();
        end
        idle();
        n_cmp++;
        if (a_cnt !== 6'd31 || b_cnt !== 6'd31) begin
            n_err++; $display("FAIL fill_cnt got %0d/%0d want 31/31", a_cnt, b_cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (a_cnt !== 6'd0 || b_cnt !== 6'd0) begin
            n_err++; $display("FAIL fill_reset got %0d/%0d want 0/0", a_cnt, b_cnt);
        end
    endtask

    task automatic test_random();
        int a;
        logic [DW-1:0] ea, eb;
        bit ba, bb;
        for (int n = 0; n < 400; n++) begin
            rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wr_en = NW'($urandom);
            wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wr_data = {$urandom, $urandom};
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            #2;
            for (int i = 0; i < NR; i++) begin
                a = int'(rd_addr[i*AW +: AW]);
                ea = ma[a]; eb = mb[a]; ba = pa[a]; bb = pb[a];
                for (int j = 0; j < NW; j++) begin
                    if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                        ea = wr_data[j*DW +: DW];
                        ba = 1'b0;
                    end
                end
                if (a == 0) begin
                    ea = '0; eb = '0; ba = 1'b0; bb = 1'b0;
                end
                n_cmp++;
                if (a_rd_data[i*DW +: DW] !== ea) begin
                    n_err++; $display("FAIL rnd_rd_a p%0d r%0d got %h want %h", i, a, a_rd_data[i*DW +: DW], ea);
                end
                n_cmp++;
                if (b_rd_data[i*DW +: DW] !== eb) begin
                    n_err++; $display("FAIL rnd_rd_b p%0d r%0d got %h want %h", i, a, b_rd_data[i*DW +: DW], eb);
                end
                n_cmp++;
                if (a_busy[i] !== ba || b_busy[i] !== bb) begin
                    n_err++; $display("FAIL rnd_busy p%0d r%0d got %b/%b want %b/%b", i, a, a_busy[i], b_busy[i], ba, bb);
                end
            end
            tick();
            n_cmp++;
            if (int'(a_cnt) != count_a() || int'(b_cnt) != count_b()) begin
                n_err++; $display("FAIL rnd_cnt got %0d/%0d want %0d/%0d", a_cnt, b_cnt, count_a(), count_b());
            end
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
        idle();
        #1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_bypass();
        test_zero();
        test_priority();
        test_scoreboard();
        test_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
